// File: rtl/data_request_responder.sv
// data_request_responder: in-order request FIFO serving a single-port word memory.
// Optional counters (stat_reads/stat_writes/stat_drops) under DATA_REQ_STATS_EN.
module data_request_responder #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 256,
  parameter int MEM_AW = 10,
  parameter int QDEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read1_valid,
  input  logic [ID_W-1:0]         read1_request_id,
  input  logic [ID_W-1:0]         read1_receive_id,
  input  logic [ADDR_W-1:0]       read1_address,
  input  logic                    read2_valid,
  input  logic [ID_W-1:0]         read2_request_id,
  input  logic [ID_W-1:0]         read2_receive_id,
  input  logic [ADDR_W-1:0]       read2_address,
  input  logic                    write_valid,
  input  logic [ADDR_W-1:0]       write_address,
  input  logic [DATA_W-1:0]       write_data,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_request_id,
  output logic [ID_W-1:0]         resp_receive_id,
  output logic [ADDR_W-1:0]       resp_address,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    resp_error,
  output logic [$clog2(QDEPTH):0] q_count,
  output logic                    almost_full,
  output logic                    overflow
`ifdef DATA_REQ_STATS_EN
  ,
  output logic [31:0]             stat_reads,
  output logic [31:0]             stat_writes,
  output logic [31:0]             stat_drops
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic              wr;
    logic [ID_W-1:0]   req;
    logic [ID_W-1:0]   rcv;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            q_mem [QDEPTH];
  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [DATA_W-1:0] mem_q;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  entry_t            cand [3];
  logic [2:0]        vld;
  logic [2:0]        acc;
  logic [CW-1:0]     pos [3];
  logic [CW-1:0]     free;
  logic [CW-1:0]     enq_cnt;
  logic [1:0]        drop_cnt;
  logic              deq;
  entry_t            head;
  logic              in_rng;
  logic [MEM_AW-1:0] idx;

  logic              s1_valid;
  logic [ID_W-1:0]   s1_req;
  logic [ID_W-1:0]   s1_rcv;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_err;

  // slot order is fixed: write, read1, read2
  always_comb begin
    cand[0] = '{wr: 1'b1, req: '0, rcv: '0,
                addr: write_address, data: write_data};
    cand[1] = '{wr: 1'b0, req: read1_request_id,
                rcv: read1_receive_id,
                addr: read1_address, data: '0};
    cand[2] = '{wr: 1'b0, req: read2_request_id,
                rcv: read2_receive_id,
                addr: read2_address, data: '0};
    vld     = {read2_valid, read1_valid, write_valid};
    free    = CW'(QDEPTH) - q_count;
    pos[0]  = '0;
    pos[1]  = CW'(vld[0]);
    pos[2]  = CW'(vld[0]) + CW'(vld[1]);
    acc     = '0;
    enq_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      acc[i]  = vld[i] && (pos[i] < free);
      enq_cnt = enq_cnt + CW'(acc[i]);
    end
    drop_cnt = 2'(vld[0]) + 2'(vld[1]) + 2'(vld[2])
             - 2'(enq_cnt);
    deq      = (q_count != '0);
    head     = q_mem[rd_ptr];
    in_rng   = (head.addr[ADDR_W-1:MEM_AW] == '0);
    idx      = head.addr[MEM_AW-1:0];
  end

  assign almost_full = (q_count >= CW'(QDEPTH - 3));

  always_ff @(posedge clk) begin
    if (acc[0]) q_mem[wr_ptr + PW'(pos[0])] <= cand[0];
    if (acc[1]) q_mem[wr_ptr + PW'(pos[1])] <= cand[1];
    if (acc[2]) q_mem[wr_ptr + PW'(pos[2])] <= cand[2];
    if (deq && in_rng) begin
      if (head.wr) mem[idx] <= head.data;
      else         mem_q    <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      q_count         <= '0;
      overflow        <= 1'b0;
      s1_valid        <= 1'b0;
      s1_req          <= '0;
      s1_rcv          <= '0;
      s1_addr         <= '0;
      s1_err          <= 1'b0;
      resp_valid      <= 1'b0;
      resp_request_id <= '0;
      resp_receive_id <= '0;
      resp_address    <= '0;
      resp_data       <= '0;
      resp_error      <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(enq_cnt);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      q_count <= q_count + enq_cnt - CW'(deq);
      if (drop_cnt != 2'd0) overflow <= 1'b1;
      s1_valid <= deq && !head.wr;
      if (deq && !head.wr) begin
        s1_req  <= head.req;
        s1_rcv  <= head.rcv;
        s1_addr <= head.addr;
        s1_err  <= !in_rng;
      end
      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_request_id <= s1_req;
        resp_receive_id <= s1_rcv;
        resp_address    <= s1_addr;
        resp_error      <= s1_err;
        resp_data       <= s1_err ? '0 : mem_q;
      end
    end
  end

`ifdef DATA_REQ_STATS_EN
  logic [32:0] dsum;

  assign dsum = {1'b0, stat_drops} + 33'(drop_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_drops  <= '0;
    end else begin
      if (deq && !head.wr && stat_reads != '1)
        stat_reads <= stat_reads + 32'd1;
      if (deq && head.wr && stat_writes != '1)
        stat_writes <= stat_writes + 32'd1;
      stat_drops <= dsum[32] ? '1 : dsum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_data_request_responder.sv
// Scoreboard bench for data_request_responder.
// Directed vectors; a negedge monitor pops expected responses.
module tb_data_request_responder;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 256;
  localparam int MEM_AW = 10;
  localparam int QDEPTH = 8;
  localparam int CW     = $clog2(QDEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              read1_valid = 1'b0;
  logic [ID_W-1:0]   read1_request_id = '0;
  logic [ID_W-1:0]   read1_receive_id = '0;
  logic [ADDR_W-1:0] read1_address = '0;
  logic              read2_valid = 1'b0;
  logic [ID_W-1:0]   read2_request_id = '0;
  logic [ID_W-1:0]   read2_receive_id = '0;
  logic [ADDR_W-1:0] read2_address = '0;
  logic              write_valid = 1'b0;
  logic [ADDR_W-1:0] write_address = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic              resp_valid;
  logic [ID_W-1:0]   resp_request_id;
  logic [ID_W-1:0]   resp_receive_id;
  logic [ADDR_W-1:0] resp_address;
  logic [DATA_W-1:0] resp_data;
  logic              resp_error;
  logic [CW-1:0]     q_count;
  logic              almost_full;
  logic              overflow;
`ifdef DATA_REQ_STATS_EN
  logic [31:0]       stat_reads;
  logic [31:0]       stat_writes;
  logic [31:0]       stat_drops;
`endif

  data_request_responder #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_AW(MEM_AW), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .read1_valid(read1_valid),
    .read1_request_id(read1_request_id),
    .read1_receive_id(read1_receive_id),
    .read1_address(read1_address),
    .read2_valid(read2_valid),
    .read2_request_id(read2_request_id),
    .read2_receive_id(read2_receive_id),
    .read2_address(read2_address),
    .write_valid(write_valid),
    .write_address(write_address),
    .write_data(write_data),
    .resp_valid(resp_valid),
    .resp_request_id(resp_request_id),
    .resp_receive_id(resp_receive_id),
    .resp_address(resp_address),
    .resp_data(resp_data),
    .resp_error(resp_error),
    .q_count(q_count),
    .almost_full(almost_full),
    .overflow(overflow)
`ifdef DATA_REQ_STATS_EN
    ,
    .stat_reads(stat_reads),
    .stat_writes(stat_writes),
    .stat_drops(stat_drops)
`endif
  );

  typedef struct {
    logic [ID_W-1:0]   req;
    logic [ID_W-1:0]   rcv;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   tp_on = 1'b0;
  int   tp_cnt = 0;
  int   tp_first = 0;
  int   tp_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [255:0] got,
                     input logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h required %0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && resp_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp got addr %0h required none",
                 resp_address);
      end else begin
        e = sb.pop_front();
        chk("resp_request_id", 256'(resp_request_id), 256'(e.req));
        chk("resp_receive_id", 256'(resp_receive_id), 256'(e.rcv));
        chk("resp_address", 256'(resp_address), 256'(e.addr));
        chk("resp_data", resp_data, e.data);
        chk("resp_error", 256'(resp_error), 256'(e.err));
      end
      if (tp_on) begin
        if (tp_cnt == 0) tp_first = cyc;
        tp_last = cyc;
        tp_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    write_valid = 1'b0;
    read1_valid = 1'b0;
    read2_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d);
    write_valid   = 1'b1;
    write_address = a;
    write_data    = d;
  endtask

  task automatic r1(input logic [ID_W-1:0] rq,
                    input logic [ID_W-1:0] rc,
                    input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d,
                    input logic e, input bit keep);
    read1_valid      = 1'b1;
    read1_request_id = rq;
    read1_receive_id = rc;
    read1_address    = a;
    if (keep) sb.push_back('{rq, rc, a, d, e});
  endtask

  task automatic r2(input logic [ID_W-1:0] rq,
                    input logic [ID_W-1:0] rc,
                    input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d,
                    input logic e, input bit keep);
    read2_valid      = 1'b1;
    read2_request_id = rq;
    read2_receive_id = rc;
    read2_address    = a;
    if (keep) sb.push_back('{rq, rc, a, d, e});
  endtask

  initial begin
    int qmax;
    bit af_seen;
    tick();
    chk("rst_resp_valid", 256'(resp_valid), 256'(0));
    chk("rst_q_count", 256'(q_count), 256'(0));
    chk("rst_overflow", 256'(overflow), 256'(0));
    chk("rst_resp_data", resp_data, 256'(0));
    chk("rst_almost_full", 256'(almost_full), 256'(0));
    rst = 1'b1;

    // single write then read, exact latency
    wr(64'd5, 256'hA5);
    tick();
    r1(8'd3, 8'd66, 64'd5, 256'hA5, 1'b0, 1'b1);
    tick();
    tick();
    chk("lat_cycle3_idle", 256'(resp_valid), 256'(0));
    tick();
    chk("lat_cycle4_valid", 256'(resp_valid), 256'(1));
    idle(2);
    chk("hold_valid_low", 256'(resp_valid), 256'(0));
    chk("hold_data", resp_data, 256'hA5);
    chk("hold_receive_id", 256'(resp_receive_id), 256'(66));

    // same-cycle triple, write ordered first
    wr(64'd7, 256'h22);
    tick();
    idle(3);
    wr(64'd7, 256'h11);
    r1(8'd1, 8'd2, 64'd7, 256'h11, 1'b0, 1'b1);
    r2(8'd4, 8'd9, 64'd7, 256'h11, 1'b0, 1'b1);
    tick();
    idle(6);

    // fill and overflow
    for (int k = 0; k < 3; k++) begin
      wr(64'(32 + k), 256'(192 + k));
      r1(8'(16 + k), 8'(32 + k), 64'(32 + k), 256'(192 + k),
         1'b0, 1'b1);
      r2(8'(48 + k), 8'(64 + k), 64'd5, 256'hA5, 1'b0, 1'b1);
      tick();
    end
    chk("fill_q_count", 256'(q_count), 256'(7));
    chk("fill_overflow", 256'(overflow), 256'(0));
    chk("fill_almost_full", 256'(almost_full), 256'(1));
    wr(64'h23, 256'hC3);
    r1(8'd1, 8'd1, 64'd5, 256'hA5, 1'b0, 1'b0);
    r2(8'd2, 8'd2, 64'd5, 256'hA5, 1'b0, 1'b0);
    tick();
    chk("drop_q_count", 256'(q_count), 256'(7));
    chk("drop_overflow", 256'(overflow), 256'(1));
    r1(8'd7, 8'd8, 64'h23, 256'hC3, 1'b0, 1'b1);
    r2(8'd9, 8'd9, 64'd5, 256'hA5, 1'b0, 1'b0);
    tick();
    chk("drop2_q_count", 256'(q_count), 256'(7));
    idle(12);
    chk("drain_q_count", 256'(q_count), 256'(0));
    chk("sticky_overflow", 256'(overflow), 256'(1));
    chk("drain_almost_full", 256'(almost_full), 256'(0));
`ifdef DATA_REQ_STATS_EN
    chk("stat_drops", 256'(stat_drops), 256'(3));
`endif

    // out-of-range requests
    wr(64'd0, 256'h77);
    tick();
    wr(64'h400, 256'hDEAD);
    r1(8'd5, 8'd6, 64'h400, 256'h0, 1'b1, 1'b1);
    r2(8'd2, 8'd3, 64'h8000_0000_0000_0005, 256'h0, 1'b1, 1'b1);
    tick();
    r1(8'd1, 8'd1, 64'd0, 256'h77, 1'b0, 1'b1);
    tick();
    idle(6);

    // reset mid-operation: five reads, two popped, then reset
    r1(8'd1, 8'd1, 64'd5, 256'hA5, 1'b0, 1'b0);
    r2(8'd2, 8'd2, 64'd5, 256'hA5, 1'b0, 1'b0);
    tick();
    r1(8'd3, 8'd3, 64'd5, 256'hA5, 1'b0, 1'b0);
    r2(8'd4, 8'd4, 64'd5, 256'hA5, 1'b0, 1'b0);
    tick();
    r1(8'd5, 8'd5, 64'd5, 256'hA5, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_q_count", 256'(q_count), 256'(0));
    chk("midrst_resp_valid", 256'(resp_valid), 256'(0));
    chk("midrst_overflow", 256'(overflow), 256'(0));
    rst = 1'b1;
    idle(6);
    chk("post_rst_q_count", 256'(q_count), 256'(0));
    r1(8'hA, 8'hB, 64'd5, 256'hA5, 1'b0, 1'b1);
    tick();
    r1(8'hC, 8'hD, 64'h21, 256'hC1, 1'b0, 1'b1);
    tick();
    idle(5);

    // back-to-back throughput
    for (int i = 0; i < 20; i++) begin
      wr(64'(256 + i), 256'(i * 3 + 1));
      tick();
    end
    idle(3);
    qmax = 0;
    af_seen = 1'b0;
    tp_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r1(8'(i), 8'(i + 1), 64'(256 + i), 256'(i * 3 + 1),
         1'b0, 1'b1);
      tick();
      if (int'(q_count) > qmax) qmax = int'(q_count);
      if (almost_full) af_seen = 1'b1;
    end
    idle(5);
    tp_on = 1'b0;
    chk("tp_resp_count", 256'(tp_cnt), 256'(20));
    chk("tp_consecutive", 256'(tp_last - tp_first), 256'(19));
    chk("tp_q_max", 256'(qmax), 256'(1));
    chk("tp_almost_full", 256'(af_seen), 256'(0));
`ifdef DATA_REQ_STATS_EN
    chk("stat_reads", 256'(stat_reads), 256'(22));
    chk("stat_writes", 256'(stat_writes), 256'(20));
    chk("stat_drops_post", 256'(stat_drops), 256'(0));
`endif

    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_request_responder.md
Name: data_request_responder

Overview:
- Memory-side endpoint for the per-thread request buses issued by the disposition stage: up to two read requests (self read, other-thread read) and one write request per cycle.
- The issuing side has no backpressure. This block therefore queues all simultaneous requests in an in-order FIFO.
- It services one request per cycle against an internal single-port synchronous word memory.
- It returns read data tagged with request_id and receive_id, so the context cache can route the data to the receiving thread.

Parameters:
- ID_W, 8, thread id width (request_id, receive_id).
- ADDR_W, 64, request address width (u64 operand).
- DATA_W, 256, data word width; one address = one word.
- MEM_AW, 10, memory index width; 2**MEM_AW words.
- QDEPTH, 8, request FIFO depth; power of two, minimum 4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- read1_valid  in  1  self-read request valid.
- read1_request_id  in  ID_W  requester id.
- read1_receive_id  in  ID_W  destination id.
- read1_address  in  ADDR_W  word address.
- read2_valid  in  1  other-read request valid.
- read2_request_id  in  ID_W  requester id.
- read2_receive_id  in  ID_W  destination id.
- read2_address  in  ADDR_W  word address.
- write_valid  in  1  write request valid.
- write_address  in  ADDR_W  word address.
- write_data  in  DATA_W  write word.
- resp_valid  out  1  read response valid, 1-cycle pulse.
- resp_request_id  out  ID_W  echoed request_id.
- resp_receive_id  out  ID_W  echoed receive_id.
- resp_address  out  ADDR_W  echoed address.
- resp_data  out  DATA_W  read word.
- resp_error  out  1  address out of range; resp_data forced to 0.
- q_count  out  $clog2(QDEPTH)+1  current FIFO occupancy.
- almost_full  out  1  q_count >= QDEPTH-3.
- overflow  out  1  sticky: a request was dropped.

Behaviour:
- Reset (rst=0, async):
  - FIFO is emptied (pointers and q_count to 0).
  - All resp_* outputs go to 0; overflow goes to 0; the in-flight pipeline is cleared.
  - Memory contents are not reset and survive reset.
  - A reset asserted mid-operation discards every queued and in-flight request; no response appears after reset release for a pre-reset request.
- Enqueue, each rising edge:
  - Valid requests are enqueued in fixed order: write, then read1, then read2. Up to 3 per edge.
  - Each entry holds the kind (read/write), ids, address and data.
- Free slots:
  - free = QDEPTH - q_count, with q_count sampled before this edge's dequeue. A same-edge dequeue does not free a slot for this edge.
  - If the number of valid requests exceeds free, the first `free` requests in the fixed order are enqueued and the rest are dropped. overflow is set and stays high until reset.
- Dequeue:
  - When the FIFO is non-empty, the head is popped at every edge.
  - q_count_next = q_count + enq - deq; it never exceeds QDEPTH.
- Address check: in range iff address[ADDR_W-1:MEM_AW] == 0. Index = address[MEM_AW-1:0].
- Write service:
  - In range: mem[index] <= data at the pop edge. Out of range: silently ignored.
  - Writes produce no response.
- Read service:
  - The memory read is issued at the pop edge; data is available the next cycle.
  - The response is registered one edge later.
  - Out-of-range read: no memory access, resp_error=1, resp_data=0, ids and address still echoed.
- Latency: a request presented in cycle N to an empty FIFO gives resp_valid in cycle N+3. Sustained throughput is 1 request per cycle.
- Ordering:
  - Strictly in FIFO order.
  - A read queued after a write to the same address returns the new data, because the write commits at its pop edge before the read's memory access.
  - A read queued before such a write returns the old data.
- Response outputs:
  - resp_valid is a single-cycle pulse per read.
  - resp_* fields hold their last value when resp_valid=0; resp_error follows the same rule.
  - There is no response ready: the consumer must accept every cycle.
- Simultaneous events: a full FIFO with 3 incoming requests and 1 pop in the same edge accepts 0 requests (see the free-slot rule above).

Optional Feature:
- Macro: DATA_REQ_STATS_EN.
- When defined, three 32-bit outputs are added:
  - stat_reads: reads serviced.
  - stat_writes: writes serviced, including ignored out-of-range writes.
  - stat_drops: requests dropped.
- The counters reset to 0, saturate at 2**32-1, and count at service/drop time.
- When not defined, the ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset, then a single write: write addr 5, data 'hA5 in cycle 0; read1 addr 5, receive_id 66, request_id 3 in cycle 1. Expected: resp_valid in cycle 4 with data 'hA5, receive_id 66, request_id 3, resp_error 0.
- Same-cycle triple: write addr 7 = 'h11, read1 addr 7, read2 addr 7 (receive_id 9), all in one cycle, with mem[7] = 'h22 beforehand. Expected: two responses on consecutive cycles, both with data 'h11; first carries read1 ids, second read2 ids.
- Overflow: with QDEPTH=8, present all three requests for 3 cycles to an empty FIFO. Expected: q_count ends at 7 (6 after the first two edges, minus pops). overflow stays 0. Then fill until a drop occurs: overflow=1 and stays 1; stat_drops equals the dropped count when DATA_REQ_STATS_EN is defined.
- Out of range: read1 addr 'h400 with MEM_AW=10. Expected: resp_valid with resp_error=1, resp_data=0, resp_address 'h400. A write to 'h400 leaves mem[0] unchanged.
- Reset mid-operation: queue 5 reads, assert rst for 1 cycle after 2 pops. Expected: no resp_valid after release, q_count=0, previously written memory data still readable.
- Back-to-back throughput: read1 valid every cycle for 20 cycles to distinct addresses. Expected: 20 responses on consecutive cycles, in order, q_count never above 1, almost_full never asserted.
